mips_data_mem: RTL and testbench
================================

# mips_data_mem

Parametrised data memory for the MIPS datapath with a request/response handshake and configurable wait states. It supports byte, halfword and word loads/stores, big-endian, with sign or zero extension. Misaligned, out-of-range and illegal-size accesses are reported as faults. It sits behind the MEM stage, and the core stalls on `req_ready`/`resp_valid`.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; any value ≥ 1.
- `WAIT_STATES`, default 1: extra cycles between acceptance and response; legal range 0..7.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` input 1: load zero-extends when 1, sign-extends when 0; ignored on stores.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: one-cycle pulse marking completion of the accepted request.
- `resp_rdata` output 32: load result; 0 for stores and faults.
- `resp_fault` output 1: qualified by `resp_valid`; access rejected.

## Operation
- Storage: `DEPTH_WORDS` x 32 array, indexed by `req_addr[31:2]`. Contents are not reset.
- Big-endian lanes: offset 0 is bits [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0]. Halfword offset 0 is [31:16], offset 2 is [15:0].
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, capture write, size, unsigned, addr and wdata into request registers. Go to WAIT if `WAIT_STATES`>0, else RESP.
  - WAIT: counter counts `WAIT_STATES` cycles, then goes to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- A fault is raised when any of these holds:
  - `req_size`=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00;
  - `req_addr[31:2]` ≥ `DEPTH_WORDS`.
- Fault handling is decoded on the captured request: no array write, `resp_rdata`=0, `resp_fault`=1, same latency as a good access.
- Store commit:
  - Only the addressed lane(s) are written; the other bytes of the word are preserved (read-modify-write or byte enables).
  - The write is committed on the edge that enters RESP.
- Load:
  - Select the lane(s) and extend to 32 bits per `req_unsigned`.
  - Word loads are never extended.
  - The result is registered on the edge entering RESP and held in `resp_rdata` while `resp_valid`=1.
- Outputs outside RESP: `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0.
- A load to an address written by the immediately preceding store returns the new data.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, wait counter 0.
- Acceptance at edge T (`req_valid`&`req_ready` sampled). `resp_valid` is high in cycle T+1+`WAIT_STATES` (edges counted after T).
- `req_ready`=0 from the cycle after acceptance through the RESP cycle inclusive.
  - Max throughput is one request per `WAIT_STATES`+2 cycles.
- Request inputs are ignored while `req_ready`=0. The master must hold `req_valid` until accepted; inputs are don't-care after acceptance.
- No response backpressure: `resp_valid` is a single-cycle pulse.
- Reset asserted mid-operation: the FSM returns to IDLE immediately.
  - A store not yet committed (before the RESP entry edge) is dropped.
  - No `resp_valid` is produced for the aborted request.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 with `WAIT_STATES`=1: `resp_valid` 2 cycles after each acceptance; load `resp_rdata`=0xDEADBEEF, `resp_fault`=0.
- Sub-word loads after the above store:
  - byte at 0x11, signed → 0xFFFFFFAD; unsigned → 0x000000AD;
  - half at 0x12, signed → 0xFFFFBEEF.
- Byte store 0x55 at 0x13, then word load at 0x10 → 0xDEADBE55, confirming the other lanes are preserved.
- Faults, each giving `resp_fault`=1, `resp_rdata`=0 and an unchanged array on re-read:
  - half at 0x11;
  - word at 0x12;
  - size 11;
  - word at 4*`DEPTH_WORDS`.
- `WAIT_STATES`=0 and 7 builds: measure acceptance-to-`resp_valid` gap = 1 and 8 cycles. Confirm `req_ready` is low throughout, and that a `req_valid` held high is accepted the cycle after RESP.
- Assert `rst` one cycle after accepting a word store of 0x12345678 to 0x20 (`WAIT_STATES`=3):
  - outputs reach reset values asynchronously; no `resp_valid` appears;
  - a later load of 0x20 returns the prior contents.

Source files
------------

// File: rtl/mips_data_mem.sv
// Data memory for the MIPS MEM stage: big-endian byte/half/word access through a
// valid/ready request and a single-cycle response pulse after WAIT_STATES extra cycles.
module mips_data_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int         IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        cur_write;
    logic [1:0]  cur_size;
    logic        cur_uns;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_fault;
    logic [IW-1:0] idx;
    logic [31:0] old_word;
    logic [4:0]  byte_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept     = (state_q == S_IDLE) && req_valid;
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    // With zero wait states the RESP-entry edge is the acceptance edge, so the
    // request has to be decoded straight from the ports in that case.
    always_comb begin
        cur_write = wr_q;
        cur_size  = size_q;
        cur_uns   = uns_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            cur_write = req_write;
            cur_size  = req_size;
            cur_uns   = req_unsigned;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    always_comb begin
        cur_fault = 1'b0;
        case (cur_size)
            SZ_BYTE: cur_fault = 1'b0;
            SZ_HALF: cur_fault = cur_addr[0];
            SZ_WORD: cur_fault = (cur_addr[1:0] != 2'b00);
            default: cur_fault = 1'b1;
        endcase
        if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS))
            cur_fault = 1'b1;
    end

    assign idx      = cur_addr[IW+1:2];
    assign old_word = mem[idx];

    // Offset 0 is the most significant byte, so the shift is (3 - offset) * 8.
    assign byte_sh  = {~cur_addr[1:0], 3'b000};
    assign byte_val = 8'(old_word >> byte_sh);
    assign half_val = cur_addr[1] ? old_word[15:0] : old_word[31:16];

    always_comb begin
        load_val = 32'h0;
        case (cur_size)
            SZ_BYTE: load_val = cur_uns ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: load_val = cur_uns ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            SZ_WORD: load_val = old_word;
            default: load_val = 32'h0;
        endcase
    end

    always_comb begin
        merged = old_word;
        case (cur_size)
            SZ_BYTE: merged = (old_word & ~(32'h0000_00FF << byte_sh))
                            | ({24'h0, cur_wdata[7:0]} << byte_sh);
            SZ_HALF: merged = cur_addr[1] ? {old_word[31:16], cur_wdata[15:0]}
                                          : {cur_wdata[15:0], old_word[15:0]};
            SZ_WORD: merged = cur_wdata;
            default: merged = old_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_write && !cur_fault)
            mem[idx] <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else if (enter_resp) begin
            fault_q <= cur_fault;
            rdata_q <= (cur_write || cur_fault) ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == WS_LAST) begin
                    state_d = S_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_fault = 1'b0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_fault = fault_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem: four instances with WAIT_STATES 1, 0, 7 and 3,
// each scenario task checks its own results against hand-computed values.
module tb_mips_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic [3:0]       rst;
    logic [3:0]       req_valid, req_write, req_unsigned;
    logic [3:0][1:0]  req_size;
    logic [3:0][31:0] req_addr, req_wdata;
    logic [3:0]       req_ready, resp_valid, resp_fault;
    logic [3:0][31:0] resp_rdata;

    // Instance 0: WS=1, 1: WS=0, 2: WS=7, 3: WS=3
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 7 : 3;
        mips_data_mem #(.DEPTH_WORDS(256), .WAIT_STATES(WS)) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_write    (req_write[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .resp_valid   (resp_valid[g]),
            .resp_rdata   (resp_rdata[g]),
            .resp_fault   (resp_fault[g])
        );
    end

    // One transaction; gap = edges from acceptance to the edge sampling resp_valid.
    // hs_ok drops if ready rises early, acceptance never happens, or the pulse lasts >1 cycle.
    task automatic do_req(input int k, input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int gap,
                          output logic hs_ok);
        int n;
        hs_ok = 1'b1; gap = -1; rd = 32'h0; flt = 1'b0;
        @(negedge clk);
        req_valid[k] = 1'b1; req_write[k] = w; req_size[k] = sz;
        req_unsigned[k] = uns; req_addr[k] = a; req_wdata[k] = wd;
        n = 0;
        while (!req_ready[k] && n < 20) begin @(negedge clk); n++; end
        if (!req_ready[k]) hs_ok = 1'b0;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        n = 0;
        while (!resp_valid[k] && n < 40) begin
            if (req_ready[k]) hs_ok = 1'b0;
            @(posedge clk); #1; n++;
        end
        if (req_ready[k]) hs_ok = 1'b0;
        if (resp_valid[k]) begin gap = n + 1; rd = resp_rdata[k]; flt = resp_fault[k]; end
        @(posedge clk); #1;
        if (resp_valid[k]) hs_ok = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 ||
                resp_rdata[k] !== 32'h0 || resp_fault[k] !== 1'b0) begin
                errs++;
                $display("FAIL reset[%0d]: ready=%b valid=%b rdata=%h fault=%b, want 1 0 0 0",
                         k, req_ready[k], resp_valid[k], resp_rdata[k], resp_fault[k]);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic flt, hs; int gap;
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, flt, gap, hs);
        checks++;
        if (rd !== 32'h0 || flt !== 1'b0 || gap != 2 || !hs) begin
            errs++;
            $display("FAIL word_store: rdata=%h fault=%b gap=%0d hs=%b, want 0 0 2 1", rd, flt, gap, hs);
        end
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, gap, hs);
        checks++;
        if (rd !== 32'hDEADBEEF || flt !== 1'b0 || gap != 2 || !hs) begin
            errs++;
            $display("FAIL word_load: rdata=%h fault=%b gap=%0d hs=%b, want deadbeef 0 2 1", rd, flt, gap, hs);
        end
    endtask

    task automatic test_subword();
        logic [31:0] ad [8] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h10, 32'h13, 32'h10};
        logic [1:0]  sz [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
        logic        un [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ex [8] = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFBEEF, 32'h0000BEEF,
                                32'hFFFFDEAD, 32'h000000DE, 32'hFFFFFFEF, 32'hDEADBEEF};
        logic [31:0] rd; logic flt, hs; int gap;
        for (int i = 0; i < 8; i++) begin
            do_req(0, 1'b0, sz[i], un[i], ad[i], 32'h0, rd, flt, gap, hs);
            checks++;
            if (rd !== ex[i] || flt !== 1'b0 || gap != 2 || !hs) begin
                errs++;
                $display("FAIL subword_load[%0d]: rdata=%h fault=%b gap=%0d hs=%b, want %h 0 2 1",
                         i, rd, flt, gap, hs, ex[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic flt, hs; int gap;
        do_req(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAAAA55, rd, flt, gap, hs);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, gap, hs);
        checks++;
        if (rd !== 32'hDEADBE55 || flt !== 1'b0 || gap != 2 || !hs) begin
            errs++;
            $display("FAIL byte_store: rdata=%h fault=%b gap=%0d hs=%b, want deadbe55 0 2 1", rd, flt, gap, hs);
        end
    endtask

    task automatic test_faults();
        logic        wr [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [6] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01};
        logic [31:0] ad [6] = '{32'h11, 32'h12, 32'h10, 32'h400, 32'h400, 32'h13};
        logic [31:0] wd [6] = '{32'h1234, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0, 32'h0};
        logic [31:0] rd; logic flt, hs; int gap;
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, rd, flt, gap, hs);
        checks++;
        if (flt !== 1'b0 || gap != 2 || !hs) begin
            errs++;
            $display("FAIL zero_store: fault=%b gap=%0d hs=%b, want 0 2 1", flt, gap, hs);
        end
        for (int i = 0; i < 6; i++) begin
            do_req(0, wr[i], sz[i], 1'b0, ad[i], wd[i], rd, flt, gap, hs);
            checks++;
            if (rd !== 32'h0 || flt !== 1'b1 || gap != 2 || !hs) begin
                errs++;
                $display("FAIL fault[%0d]: rdata=%h fault=%b gap=%0d hs=%b, want 0 1 2 1", i, rd, flt, gap, hs);
            end
        end
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, gap, hs);
        checks++;
        if (rd !== 32'hDEADBE55 || flt !== 1'b0) begin
            errs++;
            $display("FAIL fault_reread_10: rdata=%h fault=%b, want deadbe55 0", rd, flt);
        end
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, flt, gap, hs);
        checks++;
        if (rd !== 32'h0 || flt !== 1'b0) begin
            errs++;
            $display("FAIL fault_reread_00: rdata=%h fault=%b, want 00000000 0", rd, flt);
        end
    endtask

    task automatic test_half_store();
        logic [31:0] rd; logic flt, hs; int gap;
        do_req(0, 1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, rd, flt, gap, hs);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, gap, hs);
        checks++;
        if (rd !== 32'h1234BE55 || flt !== 1'b0) begin
            errs++;
            $display("FAIL half_store_hi: rdata=%h fault=%b, want 1234be55 0", rd, flt);
        end
        do_req(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE, rd, flt, gap, hs);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, gap, hs);
        checks++;
        if (rd !== 32'h1234CAFE || flt !== 1'b0) begin
            errs++;
            $display("FAIL half_store_lo: rdata=%h fault=%b, want 1234cafe 0", rd, flt);
        end
    endtask

    task automatic test_latency();
        int          kk [2] = '{1, 2};
        int          eg [2] = '{1, 8};
        logic [31:0] rd; logic flt, hs; int gap;
        for (int i = 0; i < 2; i++) begin
            do_req(kk[i], 1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5A5A5, rd, flt, gap, hs);
            checks++;
            if (gap != eg[i] || flt !== 1'b0 || !hs) begin
                errs++;
                $display("FAIL latency_store[%0d]: gap=%0d fault=%b hs=%b, want %0d 0 1", kk[i], gap, flt, hs, eg[i]);
            end
            do_req(kk[i], 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, flt, gap, hs);
            checks++;
            if (gap != eg[i] || rd !== 32'hA5A5A5A5 || !hs) begin
                errs++;
                $display("FAIL latency_load[%0d]: gap=%0d rdata=%h hs=%b, want %0d a5a5a5a5 1", kk[i], gap, rd, hs, eg[i]);
            end
        end
    endtask

    // req_valid held high: the next request is accepted in the cycle after RESP.
    task automatic test_back_to_back();
        int kk [2] = '{1, 2};
        int ep [2] = '{2, 9};
        int n, rdy;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_valid[kk[i]] = 1'b1; req_write[kk[i]] = 1'b0; req_size[kk[i]] = 2'b10;
            req_unsigned[kk[i]] = 1'b0; req_addr[kk[i]] = 32'h40;
            n = 0;
            while (!resp_valid[kk[i]] && n < 40) begin @(posedge clk); #1; n++; end
            n = 0; rdy = 0;
            do begin
                @(posedge clk); #1; n++;
                if (req_ready[kk[i]]) rdy++;
            end while (!resp_valid[kk[i]] && n < 40);
            checks++;
            if (n != ep[i] || rdy != 1 || resp_rdata[kk[i]] !== 32'hA5A5A5A5) begin
                errs++;
                $display("FAIL back_to_back[%0d]: period=%0d ready_cycles=%0d rdata=%h, want %0d 1 a5a5a5a5",
                         kk[i], n, rdy, resp_rdata[kk[i]], ep[i]);
            end
            req_valid[kk[i]] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd; logic flt, hs; int gap;
        logic        was_busy, saw_resp;
        do_req(3, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, rd, flt, gap, hs);
        checks++;
        if (gap != 4 || flt !== 1'b0 || !hs) begin
            errs++;
            $display("FAIL ws3_store: gap=%0d fault=%b hs=%b, want 4 0 1", gap, flt, hs);
        end
        @(negedge clk);
        req_valid[3] = 1'b1; req_write[3] = 1'b1; req_size[3] = 2'b10;
        req_addr[3] = 32'h20; req_wdata[3] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        @(posedge clk); #1;
        was_busy = !req_ready[3];
        rst[3] = 1'b1;
        #1;
        checks++;
        if (!was_busy || req_ready[3] !== 1'b1 || resp_valid[3] !== 1'b0 ||
            resp_rdata[3] !== 32'h0 || resp_fault[3] !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: busy_before=%b ready=%b valid=%b rdata=%h fault=%b, want 1 1 0 0 0",
                     was_busy, req_ready[3], resp_valid[3], resp_rdata[3], resp_fault[3]);
        end
        saw_resp = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (resp_valid[3]) saw_resp = 1'b1; end
        @(negedge clk);
        rst[3] = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (resp_valid[3]) saw_resp = 1'b1; end
        checks++;
        if (saw_resp) begin
            errs++;
            $display("FAIL aborted_resp: resp_valid seen=%b, want 0", saw_resp);
        end
        do_req(3, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, flt, gap, hs);
        checks++;
        if (rd !== 32'hCAFEF00D || flt !== 1'b0 || gap != 4 || !hs) begin
            errs++;
            $display("FAIL dropped_store: rdata=%h fault=%b gap=%0d hs=%b, want cafef00d 0 4 1", rd, flt, gap, hs);
        end
    endtask

    initial begin
        rst          = 4'hF;
        req_valid    = '0;
        req_write    = '0;
        req_unsigned = '0;
        req_size     = '0;
        req_addr     = '0;
        req_wdata    = '0;
        #2;
        test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 4'h0;
        test_word();
        test_subword();
        test_byte_store();
        test_faults();
        test_half_store();
        test_latency();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
